multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, active-high synchronous reset sampled on rising clk.
REQ-003 SHALL have port op, input, 7, opcode field from the instruction register.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-006 SHALL have ports PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Branch, output, 1 each, datapath enables and select.
REQ-007 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, output, 2 each, datapath selects.
REQ-008 SHALL have ports instr_done, output, 1 (last cycle of an instruction), illegal_op, output, 1 (unsupported opcode pulse), and state, output, 4 (current state, debug).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ; encoding 0..10 in that order, driven on state.
REQ-010 SHALL use these encodings: ALUSrcA 00 PC, 01 OldPC, 10 rd1; ALUSrcB 00 rd2, 01 imm, 10 const 4; ResultSrc 00 ALUOut, 01 Data, 10 ALUResult; AdrSrc 0 PC, 1 Result; ALUOp 00 add, 01 sub, 10 funct-decoded.
REQ-011 SHALL decode ImmSrc combinationally from op: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, other -> 00.
REQ-012 SHALL drive PCWrite = PCUpdate OR (Branch AND zero), where PCUpdate is the internal per-state signal.
REQ-013 FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10; IRWrite and PCUpdate = mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-014 DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00; next by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1101111 -> JAL, 1100011 -> BEQ, other -> FETCH with illegal_op=1 and instr_done=1 for this cycle.
REQ-015 MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00; op 0000011 -> MEMREAD, else MEMWRITE.
REQ-016 MEMREAD: ResultSrc 00, AdrSrc 1; stay while mem_ready=0, else MEMWB.
REQ-017 MEMWB: ResultSrc 01, RegWrite 1, instr_done 1 -> FETCH.
REQ-018 MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1 held until mem_ready=1; instr_done = mem_ready; mem_ready=1 -> FETCH.
REQ-019 EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10 -> ALUWB; EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10 -> ALUWB.
REQ-020 ALUWB: ResultSrc 00, RegWrite 1, instr_done 1 -> FETCH.
REQ-021 JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1 -> ALUWB.
REQ-022 BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1, instr_done 1 -> FETCH; PC loads only if zero=1 in this cycle.
REQ-023 Any output not listed for a state SHALL be 0; op SHALL be ignored outside DECODE and MEMADR.
REQ-024 Latency (mem_ready=1 throughout): lw 5, sw 4, R/I-ALU 4, jal 4, beq 3, illegal 2 cycles from FETCH entry to return to FETCH.
REQ-025 An unreachable state encoding (11..15) SHALL transition to FETCH on the next edge with all enables 0.

Reset
REQ-026 reset=1 at a rising edge SHALL force state to FETCH regardless of current state, including mid-instruction stalls.
REQ-027 While reset=1, PCWrite, IRWrite, RegWrite, MemWrite, instr_done and illegal_op SHALL be 0; other outputs take FETCH values; reset overrides mem_ready.

Verification
REQ-028 reset pulse then op=0000011, mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB with ResultSrc 01.
REQ-029 op=0100011, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, instr_done once, then FETCH.
REQ-030 op=1100011 with zero=1 then repeat with zero=0 -> PCWrite=1 in BEQ only for zero=1; ImmSrc=10.
REQ-031 op=1101111 -> states 0,1,9,8,0; PCWrite=1 in FETCH and JAL; ImmSrc=11.
REQ-032 op=1111111 -> DECODE asserts illegal_op=1 one cycle, next state FETCH, no RegWrite/MemWrite.
REQ-033 reset asserted in MEMREAD with mem_ready=0 -> next state FETCH, all write enables 0 during reset.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller.
//
// Sequences each instruction through FETCH/DECODE and an opcode-specific path,
// producing datapath enables and mux selects for a shared-ALU multicycle datapath.
//
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset      - synchronous active-high reset, forces FETCH
//   op         - 7-bit opcode from the instruction register
//   zero       - ALU zero flag, qualifies branch PC load
//   mem_ready  - memory completes the current access this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Branch - enables / 1-bit select
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc           - 2-bit datapath selects
//   instr_done - last cycle of the current instruction
//   illegal_op - pulse in DECODE for an unsupported opcode
//   state      - current state encoding (debug)
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       Branch,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    state_e state_q, state_d;
    logic   pc_update;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Immediate format depends only on the opcode, independent of state.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OpLoad, OpItype: ImmSrc = 2'b00;
            OpStore:         ImmSrc = 2'b01;
            OpBeq:           ImmSrc = 2'b10;
            OpJal:           ImmSrc = 2'b11;
            default:         ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = StFetch;
        pc_update  = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        Branch     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            StFetch: begin
                AdrSrc    = 1'b0;
                ALUSrcA   = 2'b00;
                ALUSrcB   = 2'b10;
                ALUOp     = 2'b00;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
                state_d   = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b00;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecuteR;
                    OpItype:         state_d = StExecuteI;
                    OpJal:           state_d = StJal;
                    OpBeq:           state_d = StBeq;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b00;
                state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                ResultSrc = 2'b00;
                AdrSrc    = 1'b1;
                state_d   = mem_ready ? StMemWb : StMemRead;
            end
            StMemWb: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                // Write strobe held for the whole access, including the completing cycle.
                ResultSrc  = 2'b00;
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? StFetch : StMemWrite;
            end
            StExecuteR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                ResultSrc  = 2'b00;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                // ALU computes PC+4 for the link while ALUOut (target) loads the PC.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ALUOp     = 2'b00;
                ResultSrc = 2'b00;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StBeq: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUOp      = 2'b01;
                ResultSrc  = 2'b00;
                Branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            default: begin
                // Unreachable encodings recover to FETCH with everything deasserted.
                state_d = StFetch;
            end
        endcase

        // Reset wins over mem_ready: FETCH selects, but no writes or status pulses.
        if (reset) begin
            state_d    = StFetch;
            pc_update  = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            Branch     = 1'b0;
            instr_done = 1'b0;
            illegal_op = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b10;
            ALUOp      = 2'b00;
            ResultSrc  = 2'b10;
        end
    end

    assign PCWrite = pc_update | (Branch & zero);

endmodule
